// File: rtl/cgra_dma_engine.sv
// Word-granular memory-to-memory DMA engine: a read port feeds a small FIFO that drains into a write port.
// Optional macro CGRA_DMA_ALIGN_CHECK_EN rejects misaligned src/dst with a sticky error instead of truncating.
module cgra_dma_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           dma_src,
  input  logic [31:0]           dma_dst,
  input  logic [31:0]           dma_size,
  input  logic                  dma_start,
  output logic                  dma_busy_o,
  output logic                  dma_done_o,
  output logic                  dma_err_o,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_rvalid,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  input  logic                  wr_gnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [29:0]           r_words;
  logic [29:0]           r_rd_cnt;
  logic [29:0]           r_wr_cnt;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [CW-1:0]         r_fifo_cnt;
  logic [CW-1:0]         r_pend;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic                  w_start_acc;
  logic                  w_align_err;
  logic [29:0]           w_size_words;
  logic [ADDR_WIDTH-1:0] w_src;
  logic [ADDR_WIDTH-1:0] w_dst;
  logic                  w_run;
  logic                  w_rd_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_wr;
  logic [CW:0]           w_inflight;
  logic                  w_unused_bits;

  assign w_start_acc  = (r_state == S_IDLE) && dma_start;
  assign w_size_words = dma_size[31:2];
  assign w_src        = ADDR_WIDTH'({dma_src[31:2], 2'b00});
  assign w_dst        = ADDR_WIDTH'({dma_dst[31:2], 2'b00});
  assign w_unused_bits = ^{dma_size[1:0], dma_src[1:0], dma_dst[1:0]};

`ifdef CGRA_DMA_ALIGN_CHECK_EN
  logic r_err;

  assign w_align_err = (|dma_src[1:0]) || (|dma_dst[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= w_align_err;
    end
  end

  assign dma_err_o = r_err;
`else
  assign w_align_err = 1'b0;
  assign dma_err_o   = 1'b0;
`endif

  assign w_run      = (r_state == S_RUN);
  // Reads granted but not yet written (in flight or buffered) never exceed the FIFO size.
  assign w_inflight = {1'b0, r_fifo_cnt} + {1'b0, r_pend};

  assign rd_req     = w_run && (r_rd_cnt != r_words) && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign rd_addr    = r_rd_addr;
  assign wr_req     = w_run && (r_fifo_cnt != '0);
  assign wr_addr    = r_wr_addr;
  assign wr_wdata   = wr_req ? r_mem[r_rptr] : '0;

  assign w_rd_fire  = rd_req && rd_gnt;
  assign w_push     = w_run && rd_rvalid;
  assign w_pop      = wr_req && wr_gnt;
  assign w_last_wr  = w_pop && (r_wr_cnt == (r_words - 30'd1));

  assign dma_busy_o = w_run;
  assign dma_done_o = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_words   <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dma_start) begin
            r_rd_addr <= w_src;
            r_wr_addr <= w_dst;
            r_words   <= w_size_words;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_state   <= (w_align_err || (w_size_words == '0)) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_rd_fire) begin
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(4);
            r_rd_cnt  <= r_rd_cnt + 30'd1;
          end
          if (w_pop) begin
            r_wr_addr <= r_wr_addr + ADDR_WIDTH'(4);
            r_wr_cnt  <= r_wr_cnt + 30'd1;
          end
          if (w_last_wr) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_words  <= '0;
          r_rd_cnt <= '0;
          r_wr_cnt <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; responses arriving outside RUN are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fifo_cnt <= '0;
      r_pend     <= '0;
    end else if (r_state == S_DONE) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fifo_cnt <= '0;
      r_pend     <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      case ({w_rd_fire, w_push})
        2'b10:   r_pend <= r_pend + CW'(1);
        2'b01:   r_pend <= r_pend - CW'(1);
        default: r_pend <= r_pend;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= rd_rdata;
    end
  end

endmodule

// File: doc/cgra_dma_engine.md
CGRA_DMA_ENGINE -- requirements
Module: cgra_dma_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width of both memory ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; transfers are whole 4-byte words.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two >=2, read-to-write buffer entries.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports dma_src / dma_dst / dma_size  input  32 each  source byte address / destination byte address / size in bytes, from CSR.
REQ-007 SHALL have port dma_start  input  1  single-cycle start pulse from CSR.
REQ-008 SHALL have ports dma_busy_o  output  1  transfer in progress; dma_done_o  output  1  one-cycle completion pulse.
REQ-009 SHALL have port dma_err_o  output  1  sticky error, cleared on next accepted start.
REQ-010 SHALL have read-request ports rd_req  output  1; rd_addr  output  ADDR_WIDTH; rd_gnt  input  1 (accepted when rd_req&&rd_gnt).
REQ-011 SHALL have read-response ports rd_rvalid  input  1; rd_rdata  input  DATA_WIDTH (one response per granted request, in order, latency >=1 cycle).
REQ-012 SHALL have write ports wr_req  output  1; wr_addr  output  ADDR_WIDTH; wr_wdata  output  DATA_WIDTH; wr_gnt  input  1 (accepted when wr_req&&wr_gnt).

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; DONE lasts exactly one cycle.
REQ-014 SHALL accept dma_start only in IDLE; start in RUN or DONE SHALL be ignored with no state change.
REQ-015 SHALL on accepted start latch src, dst, word count = dma_size[31:2] (dma_size[1:0] ignored) and enter RUN next cycle.
REQ-016 SHALL with word count 0 go IDLE -> DONE directly, issuing no rd_req/wr_req.
REQ-017 SHALL assert dma_busy_o exactly while in RUN and dma_done_o exactly while in DONE.
REQ-018 SHALL assert rd_req in RUN only while reads remain and (FIFO occupancy + outstanding reads) < FIFO_DEPTH; first rd_req in cycle after start.
REQ-019 SHALL hold rd_addr/rd_req stable until granted; rd_addr advances by 4 per grant, 32-bit wrap-around without error.
REQ-020 SHALL push rd_rdata into FIFO on every rd_rvalid; overflow is structurally impossible by REQ-018.
REQ-021 SHALL assert wr_req whenever FIFO non-empty, wr_wdata = FIFO head, wr_addr = dst + 4*words_written; pop on grant.
REQ-022 SHALL support simultaneous push and pop in one cycle, occupancy unchanged.
REQ-023 SHALL sustain one word per cycle when rd_gnt, rd_rvalid, wr_gnt are continuously high.
REQ-024 SHALL transition RUN -> DONE in the cycle after the final write grant; all counters cleared on return to IDLE.
REQ-025 SHALL hold rd_req, wr_req low outside RUN; address/data outputs don't-care when req low.

Reset
REQ-026 SHALL on rst_n low immediately force IDLE, FIFO empty, counters 0, all outputs 0, including mid-transfer; outstanding responses are dropped.
REQ-027 SHALL ignore rd_rvalid while in IDLE.

Configuration
REQ-028 SHALL with macro CGRA_DMA_ALIGN_CHECK_EN defined check dma_src[1:0] and dma_dst[1:0] on start; if nonzero, set dma_err_o, issue no accesses, go IDLE -> DONE.
REQ-029 SHALL with CGRA_DMA_ALIGN_CHECK_EN undefined ignore address bits [1:0] (force to 0) and tie dma_err_o to 0.

Verification
REQ-030 SHALL cover: src=0x100, dst=0x200, size=16, all gnt high, rvalid 1-cycle latency -> 4 writes 0x200..0x20C with read data in order, done one cycle after last write grant.
REQ-031 SHALL cover: size=0 start -> done pulse next cycle, busy never high, no rd_req/wr_req.
REQ-032 SHALL cover: size=64, FIFO_DEPTH=4, wr_gnt low 20 cycles -> at most 4 read grants outstanding+buffered, then 16 correct writes.
REQ-033 SHALL cover: second dma_start during RUN -> ignored, original 16-word transfer completes unchanged.
REQ-034 SHALL cover: rst_n low after 3 of 8 writes -> all outputs 0 asynchronously; new start then completes full transfer correctly.
REQ-035 SHALL cover: with CGRA_DMA_ALIGN_CHECK_EN, src=0x102 -> dma_err_o=1, done pulse, no accesses; next aligned start clears err.
